// File: rtl/wall_erase_scheduler.sv
// rtl/wall_erase_scheduler.sv - two-requester wall-cell erase queue and erase sequencer.
// Optional build macro WES_DEDUP_EN: requests matching a queued cell are accepted but not stored.
module wall_erase_scheduler #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0_valid,
  input  logic [7:0] req0_xy,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_xy,
  output logic       req1_ready,
  output logic       bus_req,
  input  logic       bus_gnt,
  output logic       erase_en,
  output logic [7:0] erase_xy,
  input  logic       erase_finish,
  output logic       erase_done,
  output logic [4:0] pending,
  output logic       busy
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ERASE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [4:0]    count_q, count_d;
  logic          rr_last_q, rr_last_d;

  logic       pop;
  logic       full;
  logic       can_push;
  logic       sel1;
  logic       accept;
  logic       dup;
  logic       store;
  logic [7:0] push_xy;

  // The DONE-cycle pop frees the head slot, so a full queue may take a push that same cycle.
  assign pop      = (state_q == S_DONE);
  assign full     = (count_q == 5'(DEPTH));
  assign can_push = !full || pop;

  // rr_last_q=1 means requester 1 won last, so requester 0 takes the next tie.
  assign sel1       = req1_valid && (!req0_valid || !rr_last_q);
  assign req0_ready = can_push && req0_valid && !sel1;
  assign req1_ready = can_push && req1_valid && sel1;
  assign accept     = req0_ready || req1_ready;
  assign push_xy    = sel1 ? req1_xy : req0_xy;

`ifdef WES_DEDUP_EN
  logic [DEPTH-1:0] hit;

  for (genvar g = 0; g < DEPTH; g++) begin : g_dup
    logic [PW-1:0] slot;
    assign slot   = head_q + PW'(g);
    assign hit[g] = (5'(g) < count_q) && (mem_q[slot] == push_xy);
  end

  assign dup = |hit;
`else
  assign dup = 1'b0;
`endif

  assign store = accept && !dup;

  always_comb begin
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    rr_last_d = rr_last_q;
    if (store) begin
      tail_d = tail_q + PW'(1);
    end
    if (pop) begin
      head_d = head_q + PW'(1);
    end
    if (accept) begin
      rr_last_d = sel1;
    end
    case ({store, pop})
      2'b10:   count_d = count_q + 5'd1;
      2'b01:   count_d = count_q - 5'd1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    bus_req    = 1'b0;
    erase_en   = 1'b0;
    erase_xy   = 8'h00;
    erase_done = 1'b0;
    case (state_q)
      S_IDLE: begin
        bus_req = (count_q != 5'd0);
        if ((count_q != 5'd0) && bus_gnt) begin
          state_d = S_ERASE;
        end
      end
      S_ERASE: begin
        bus_req  = 1'b1;
        erase_en = 1'b1;
        erase_xy = mem_q[head_q];
        if (erase_finish) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        erase_done = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign pending = count_q;
  assign busy    = (state_q != S_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= 5'd0;
      rr_last_q <= 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else begin
      state_q   <= state_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      rr_last_q <= rr_last_d;
      if (store) begin
        mem_q[tail_q] <= push_xy;
      end
    end
  end

endmodule
